spi_master_ctrl: RTL and testbench

- SPI master that drives the SS_n/MOSI/MISO link into our SPI slave + RAM subsystem.
- Converts single-cycle host requests into framed SPI transactions.
- Supported requests: write-address (cmd 00), write-data (01), read-address (10), read-data (11).
- For read-data frames it captures the 8-bit byte returned on MISO. Sits between the test/host logic and SPI_wrapper.

---
 rtl/spi_master_ctrl.sv | 157 +++++++++++++++
 tb/tb_spi_master_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// SPI master: turns one-cycle host requests into framed SS_n/MOSI/MISO transactions.
// Optional SPI_MASTER_SEQ_CHK_EN adds seq_err for out-of-order rd-addr/rd-data requests.
module spi_master_ctrl #(
  parameter int RD_WAIT = 2,
  parameter int GAP     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
`ifdef SPI_MASTER_SEQ_CHK_EN
  ,
  output logic       seq_err
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_CHK, S_SHIFT, S_WAIT, S_RECV, S_GAP} state_t;

  state_t     state_q;
  logic [9:0] shreg_q;
  logic [7:0] rx_q, dout_q;
  logic [1:0] cmd_q;
  logic [3:0] bit_cnt_q;
  logic [2:0] gap_cnt_q;
  logic       busy_q, done_q, dv_q, ss_n_q, mosi_q;
  logic       accept;

  // busy drops in the last GAP cycle so a waiting start lands exactly GAP cycles after SS_n rises
  assign accept = start && !busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      rx_q      <= '0;
      dout_q    <= '0;
      cmd_q     <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dv_q      <= 1'b0;
      ss_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dv_q   <= 1'b0;
      if (accept) begin
        state_q   <= S_CHK;
        shreg_q   <= {cmd, din};
        cmd_q     <= cmd;
        mosi_q    <= cmd[1];
        ss_n_q    <= 1'b0;
        busy_q    <= 1'b1;
        bit_cnt_q <= '0;
      end else begin
        case (state_q)
          S_CHK: begin
            state_q   <= S_SHIFT;
            mosi_q    <= shreg_q[9];
            shreg_q   <= {shreg_q[8:0], 1'b0};
            bit_cnt_q <= '0;
          end
          S_SHIFT: begin
            if (bit_cnt_q == 4'd9) begin
              mosi_q    <= 1'b0;
              bit_cnt_q <= '0;
              if (cmd_q == 2'b11) begin
                state_q <= S_WAIT;
              end else begin
                state_q   <= S_GAP;
                ss_n_q    <= 1'b1;
                done_q    <= 1'b1;
                gap_cnt_q <= 3'd1;
                busy_q    <= (GAP != 1);
              end
            end else begin
              mosi_q    <= shreg_q[9];
              shreg_q   <= {shreg_q[8:0], 1'b0};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
          S_WAIT: begin
            if (bit_cnt_q == 4'(RD_WAIT - 1)) begin
              state_q   <= S_RECV;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
          S_RECV: begin
            rx_q <= {rx_q[6:0], MISO};
            if (bit_cnt_q == 4'd7) begin
              dout_q    <= {rx_q[6:0], MISO};
              dv_q      <= 1'b1;
              done_q    <= 1'b1;
              ss_n_q    <= 1'b1;
              state_q   <= S_GAP;
              gap_cnt_q <= 3'd1;
              busy_q    <= (GAP != 1);
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
          S_GAP: begin
            if (gap_cnt_q >= 3'(GAP)) begin
              state_q <= S_IDLE;
            end else begin
              gap_cnt_q <= gap_cnt_q + 3'd1;
              busy_q    <= ((gap_cnt_q + 3'd1) != 3'(GAP));
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign SS_n       = ss_n_q;
  assign MOSI       = mosi_q;

`ifdef SPI_MASTER_SEQ_CHK_EN
  logic rd_armed_q, seq_err_q, armed_eff;

  // Completion and a back-to-back accept can share an edge, so judge against the updated flag
  always_comb begin
    armed_eff = rd_armed_q;
    if (done_q && cmd_q == 2'b10) armed_eff = 1'b1;
    if (done_q && cmd_q == 2'b11) armed_eff = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_armed_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      rd_armed_q <= armed_eff;
      seq_err_q  <= accept && ((cmd == 2'b11 && !armed_eff) || (cmd == 2'b10 && armed_eff));
    end
  end

  assign seq_err = seq_err_q;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: frame shape, MOSI bits, MISO capture, gaps, abort.
module tb_spi_master_ctrl;
  localparam int RD_WAIT = 2;
  localparam int GAP     = 1;

  logic       clk = 1'b0;
  logic       rst, start, MISO;
  logic [1:0] cmd;
  logic [7:0] din;
  logic       busy, done, dout_valid, SS_n, MOSI;
  logic [7:0] dout;
`ifdef SPI_MASTER_SEQ_CHK_EN
  logic       seq_err;
`endif

  int checks = 0;
  int errors = 0;

  int          low_cnt, done_cnt, dv_cnt, both_cnt, seq_cnt;
  logic [31:0] mosi_bits;

  spi_master_ctrl #(.RD_WAIT(RD_WAIT), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .din(din),
    .busy(busy), .done(done), .dout(dout), .dout_valid(dout_valid),
    .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
`ifdef SPI_MASTER_SEQ_CHK_EN
    , .seq_err(seq_err)
`endif
  );

  always #5 clk = ~clk;

  // Issues one request and observes it on negedges until busy drops; the slave
  // model drives rx MSB first during RECV and holds MISO high elsewhere.
  task automatic do_frame(input logic [1:0] c, input logic [7:0] d, input logic [7:0] rx, input int inj);
    low_cnt = 0; mosi_bits = '0; done_cnt = 0; dv_cnt = 0; both_cnt = 0; seq_cnt = 0;
    @(negedge clk); start = 1'b1; cmd = c; din = d;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i == inj) begin start = 1'b1; cmd = 2'b01; din = 8'hFF; end
      else if (i == inj + 1) start = 1'b0;
      if (i >= 11 + RD_WAIT && i < 19 + RD_WAIT) begin
        int bi;
        bi = 18 + RD_WAIT - i;
        MISO = rx[bi];
      end else MISO = 1'b1;
      if (!SS_n) begin low_cnt++; mosi_bits = {mosi_bits[30:0], MOSI}; end
      if (done) done_cnt++;
      if (dout_valid) dv_cnt++;
      if (done && dout_valid) both_cnt++;
`ifdef SPI_MASTER_SEQ_CHK_EN
      if (seq_err) seq_cnt++;
`endif
      if (!busy) break;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (busy) begin errors++; $display("FAIL frame_timeout busy=%0b want 0", busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cmd = '0; din = '0; MISO = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL rst_ss_n got %b want 1", SS_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL rst_mosi got %b want 0", MOSI); end
    checks++; if ({done, dout_valid} !== 2'b00) begin errors++; $display("FAIL rst_pulses got %b want 00", {done, dout_valid}); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rst_dout got %h want 00", dout); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({SS_n, busy} !== 2'b10) begin errors++; $display("FAIL idle_after_rst got %b want 10", {SS_n, busy}); end
  endtask

  task automatic test_abort();
    int bad;
    @(negedge clk); start = 1'b1; cmd = 2'b00; din = 8'hA5;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (SS_n !== 1'b0) begin errors++; $display("FAIL abort_pre_ss_n got %b want 0", SS_n); end
    #2 rst = 1'b1;
    #1;
    checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL abort_ss_n got %b want 1", SS_n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    @(negedge clk); rst = 1'b0;
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || !SS_n || busy) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL abort_quiet got %0d want 0", bad); end
    do_frame(2'b00, 8'hA5, 8'h00, -1);
    checks++; if (low_cnt != 11) begin errors++; $display("FAIL post_abort_len got %0d want 11", low_cnt); end
    checks++; if (mosi_bits[10:0] !== 11'b00010100101) begin errors++; $display("FAIL post_abort_mosi got %b want 00010100101", mosi_bits[10:0]); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL post_abort_done got %0d want 1", done_cnt); end
    checks++; if (dout !== 8'h00 || dv_cnt != 0) begin errors++; $display("FAIL post_abort_dout got %h/%0d want 00/0", dout, dv_cnt); end
  endtask

  task automatic test_read();
    do_frame(2'b01, 8'h3C, 8'h00, -1);
    checks++; if (mosi_bits[10:0] !== 11'b00100111100 || low_cnt != 11) begin errors++; $display("FAIL wrdata_mosi got %b/%0d want 00100111100/11", mosi_bits[10:0], low_cnt); end
    checks++; if (dout !== 8'h00 || dv_cnt != 0) begin errors++; $display("FAIL wrdata_dout got %h/%0d want 00/0", dout, dv_cnt); end
    do_frame(2'b10, 8'hA5, 8'h00, -1);
    checks++; if (mosi_bits[10:0] !== 11'b11010100101 || low_cnt != 11) begin errors++; $display("FAIL rdaddr_mosi got %b/%0d want 11010100101/11", mosi_bits[10:0], low_cnt); end
    do_frame(2'b11, 8'h00, 8'h3C, -1);
    checks++; if (low_cnt != 21) begin errors++; $display("FAIL rddata_len got %0d want 21", low_cnt); end
    checks++; if (mosi_bits[20:0] !== 21'h1C0000) begin errors++; $display("FAIL rddata_mosi got %h want 1c0000", mosi_bits[20:0]); end
    checks++; if (dout !== 8'h3C) begin errors++; $display("FAIL rddata_dout got %h want 3c", dout); end
    checks++; if (dv_cnt != 1 || done_cnt != 1 || both_cnt != 1) begin errors++; $display("FAIL rddata_pulses got dv=%0d done=%0d both=%0d want 1/1/1", dv_cnt, done_cnt, both_cnt); end
    do_frame(2'b11, 8'h00, 8'hA5, -1);
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL rddata2_dout got %h want a5", dout); end
    do_frame(2'b00, 8'h12, 8'h00, -1);
    checks++; if (dout !== 8'hA5 || dv_cnt != 0) begin errors++; $display("FAIL dout_hold got %h/%0d want a5/0", dout, dv_cnt); end
  endtask

  task automatic test_ignored_start();
    int bad;
    do_frame(2'b01, 8'h3C, 8'h00, 4);
    checks++; if (mosi_bits[10:0] !== 11'b00100111100 || low_cnt != 11) begin errors++; $display("FAIL ign_mosi got %b/%0d want 00100111100/11", mosi_bits[10:0], low_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL ign_done got %0d want 1", done_cnt); end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!SS_n || busy) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ign_no_queue got %0d want 0", bad); end
  endtask

  task automatic test_back_to_back();
    int hi_run, gaps, bad_gap, lows, dones, bad;
    logic seen_low;
    hi_run = 0; gaps = 0; bad_gap = 0; lows = 0; dones = 0; seen_low = 1'b0;
    @(negedge clk); start = 1'b1; cmd = 2'b00; din = 8'hA5;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!SS_n) begin
        if (seen_low && hi_run > 0) begin gaps++; if (hi_run != GAP) bad_gap++; end
        hi_run = 0; seen_low = 1'b1; lows++;
      end else hi_run++;
      if (done) dones++;
      if (dones == 3) break;
    end
    start = 1'b0;
    checks++; if (dones != 3) begin errors++; $display("FAIL b2b_done got %0d want 3", dones); end
    checks++; if (lows != 33) begin errors++; $display("FAIL b2b_low got %0d want 33", lows); end
    checks++; if (gaps != 2 || bad_gap != 0) begin errors++; $display("FAIL b2b_gap got gaps=%0d bad=%0d want 2/0", gaps, bad_gap); end
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (!SS_n) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_stop got %0d want 0", bad); end
  endtask

`ifdef SPI_MASTER_SEQ_CHK_EN
  task automatic test_seq_chk();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    do_frame(2'b11, 8'h00, 8'h55, -1);
    checks++; if (seq_cnt != 1) begin errors++; $display("FAIL seq_rd_first got %0d want 1", seq_cnt); end
    do_frame(2'b10, 8'h01, 8'h00, -1);
    checks++; if (seq_cnt != 0) begin errors++; $display("FAIL seq_addr got %0d want 0", seq_cnt); end
    do_frame(2'b11, 8'h00, 8'h66, -1);
    checks++; if (seq_cnt != 0) begin errors++; $display("FAIL seq_ok_rd got %0d want 0", seq_cnt); end
    do_frame(2'b10, 8'h02, 8'h00, -1);
    checks++; if (seq_cnt != 0) begin errors++; $display("FAIL seq_addr2 got %0d want 0", seq_cnt); end
    do_frame(2'b10, 8'h03, 8'h00, -1);
    checks++; if (seq_cnt != 1) begin errors++; $display("FAIL seq_double_addr got %0d want 1", seq_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_abort();
    test_read();
    test_ignored_start();
    test_back_to_back();
`ifdef SPI_MASTER_SEQ_CHK_EN
    test_seq_chk();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
